// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_unit
// Purpose  : Initiator side of the CSR register-file port. Executes one Zicsr
//            op (read, compute new value, conditional write-back) and
//            returns the old CSR value.
// Revision : 1.0 - initial release
// ============================================================================

module csr_access_unit #(
  parameter bit RO_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_rs1_idx,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rd_val,
  output logic        resp_illegal,
  output logic [11:0] csr_r_addr,
  input  logic [31:0] csr_r_val,
  output logic [11:0] csr_w_addr,
  output logic [31:0] csr_w_val,
  output logic        w_enable
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] c_OP_RW = 2'b01;
  localparam logic [1:0] c_OP_RS = 2'b10;
  localparam logic [1:0] c_OP_RC = 2'b11;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;

  // Only funct3[1:0] is needed after operand selection; funct3[2] picks the source.
  logic [1:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_src;
  logic        r_idx_nz;
  logic [31:0] r_old;

  logic        w_accept;
  logic [31:0] w_src;
  logic        w_write_req;
  logic        w_illegal;
  logic [31:0] w_new_val;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_src    = req_funct3[2] ? {27'b0, req_rs1_idx} : req_rs1_val;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next_state = S_READ;
      S_READ:  w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_RESP;
      S_RESP:  if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request capture and old-value capture; request ports are ignored once busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op     <= 2'b00;
      r_addr   <= 12'h000;
      r_src    <= 32'h0;
      r_idx_nz <= 1'b0;
      r_old    <= 32'h0;
    end else begin
      if (w_accept) begin
        r_op     <= req_funct3[1:0];
        r_addr   <= req_csr_addr;
        r_src    <= w_src;
        r_idx_nz <= (req_rs1_idx != 5'd0);
      end
      if (r_state == S_READ) begin
        r_old <= csr_r_val;
      end
    end
  end

  // Set/clear forms with rs1=x0 (or zimm=0) are pure reads, whatever src holds.
  assign w_write_req = (r_op == c_OP_RW) || r_idx_nz;
  assign w_illegal   = (r_op == 2'b00) ||
                       (RO_CHECK && (r_addr[11:10] == 2'b11) && w_write_req);

  always_comb begin
    w_new_val = 32'h0;
    case (r_op)
      c_OP_RW: w_new_val = r_src;
      c_OP_RS: w_new_val = r_old | r_src;
      c_OP_RC: w_new_val = r_old & ~r_src;
      default: w_new_val = 32'h0;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_illegal = 1'b0;
    resp_rd_val  = 32'h0;
    w_enable     = 1'b0;
    csr_r_addr   = r_addr;
    csr_w_addr   = r_addr;
    csr_w_val    = w_new_val;
    case (r_state)
      S_IDLE:  req_ready = 1'b1;
      S_READ:  ;
      // Reset gates the strobe combinationally so an abort can never write.
      S_WRITE: w_enable = w_write_req && !w_illegal && !reset;
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_illegal = w_illegal;
        resp_rd_val  = w_illegal ? 32'h0 : r_old;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_access_unit
// Purpose  : Directed self-checking bench for csr_access_unit with a small
//            CSR register-file model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_csr_access_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rs1_idx;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd_val;
  logic        resp_illegal;
  logic [11:0] csr_r_addr;
  logic [31:0] csr_r_val;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_val;
  logic        w_enable;

  int n_checks;
  int n_errors;

  // CSR register-file model with a bench-side poke port
  logic [31:0] r_mem [0:4095];
  logic        poke_en;
  logic [11:0] poke_addr;
  logic [31:0] poke_val;

  assign csr_r_val = r_mem[csr_r_addr];

  always @(posedge clock) begin
    if (w_enable)     r_mem[csr_w_addr] <= csr_w_val;
    else if (poke_en) r_mem[poke_addr]  <= poke_val;
  end

  csr_access_unit #(.RO_CHECK(1'b1)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr_addr (req_csr_addr),
    .req_rs1_val  (req_rs1_val),
    .req_rs1_idx  (req_rs1_idx),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd_val  (resp_rd_val),
    .resp_illegal (resp_illegal),
    .csr_r_addr   (csr_r_addr),
    .csr_r_val    (csr_r_val),
    .csr_w_addr   (csr_w_addr),
    .csr_w_val    (csr_w_val),
    .w_enable     (w_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] addr, input logic [31:0] val);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_val  = val;
    @(posedge clock);
    #1;
    poke_en = 1'b0;
  endtask

  // Runs one op with inputs driven #1 after an edge; scrambles request ports once
  // accepted so the unit must use its latched copies. hold = cycles resp_ready low.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] val, input logic [4:0] idx, input int hold,
                       output logic we, output logic [31:0] wv,
                       output logic [31:0] rd, output logic ill);
    check({tag, ".ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_csr_addr = addr;
    req_rs1_val  = val;
    req_rs1_idx  = idx;
    @(posedge clock);
    #1;
    req_funct3   = 3'b001;
    req_csr_addr = 12'h0AA;
    req_rs1_val  = 32'hDEAD_BEEF;
    req_rs1_idx  = 5'd31;
    // READ cycle; request still presented to prove it is ignored while busy
    check({tag, ".rd_addr"}, {20'b0, csr_r_addr}, {20'b0, addr});
    check({tag, ".we_in_read"}, {31'b0, w_enable}, 32'd0);
    check({tag, ".busy"}, {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    we = w_enable;
    wv = csr_w_val;
    if (w_enable) check({tag, ".w_addr"}, {20'b0, csr_w_addr}, {20'b0, addr});
    resp_ready = (hold == 0);
    @(posedge clock);
    #1;
    check({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, ".we_in_resp"}, {31'b0, w_enable}, 32'd0);
    rd  = resp_rd_val;
    ill = resp_illegal;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check({tag, ".hold_valid"}, {31'b0, resp_valid}, 32'd1);
      check({tag, ".hold_rd"}, resp_rd_val, rd);
      check({tag, ".hold_ill"}, {31'b0, resp_illegal}, {31'b0, ill});
      check({tag, ".hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    check({tag, ".resp_done"}, {31'b0, resp_valid}, 32'd0);
    check({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  logic        we;
  logic [31:0] wv;
  logic [31:0] rd;
  logic        ill;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_funct3   = 3'b000;
    req_csr_addr = 12'h000;
    req_rs1_val  = 32'h0;
    req_rs1_idx  = 5'd0;
    resp_ready   = 1'b1;
    poke_en      = 1'b0;
    poke_addr    = 12'h000;
    poke_val     = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.we", {31'b0, w_enable}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst.req_ready", {31'b0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.resp_rd_val", resp_rd_val, 32'h0);
    check("rst.resp_illegal", {31'b0, resp_illegal}, 32'd0);
    check("rst.r_addr", {20'b0, csr_r_addr}, 32'h0);
    check("rst.w_addr", {20'b0, csr_w_addr}, 32'h0);
    check("rst.w_val", csr_w_val, 32'h0);

    // 1: CSRRW
    poke(12'h340, 32'h0000_00F0);
    poke(12'hC00, 32'h0000_ABCD);
    do_op("rw", 3'b001, 12'h340, 32'h1234_5678, 5'd3, 0, we, wv, rd, ill);
    check("rw.we", {31'b0, we}, 32'd1);
    check("rw.wval", wv, 32'h1234_5678);
    check("rw.rd", rd, 32'h0000_00F0);
    check("rw.ill", {31'b0, ill}, 32'd0);

    // 2: CSRRS then CSRRC
    poke(12'h340, 32'h0000_00F0);
    do_op("rs", 3'b010, 12'h340, 32'h0000_000F, 5'd5, 0, we, wv, rd, ill);
    check("rs.we", {31'b0, we}, 32'd1);
    check("rs.wval", wv, 32'h0000_00FF);
    check("rs.rd", rd, 32'h0000_00F0);
    do_op("rc", 3'b011, 12'h340, 32'h0000_00F0, 5'd5, 0, we, wv, rd, ill);
    check("rc.we", {31'b0, we}, 32'd1);
    check("rc.wval", wv, 32'h0000_000F);
    check("rc.rd", rd, 32'h0000_00FF);

    // 3: x0 / zimm=0 forms
    do_op("rs_x0", 3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0, 0, we, wv, rd, ill);
    check("rs_x0.we", {31'b0, we}, 32'd0);
    check("rs_x0.rd", rd, 32'h0000_000F);
    do_op("rsi_0", 3'b110, 12'h340, 32'hFFFF_FFFF, 5'd0, 0, we, wv, rd, ill);
    check("rsi_0.we", {31'b0, we}, 32'd0);
    check("rsi_0.rd", rd, 32'h0000_000F);
    do_op("rsi_3", 3'b110, 12'h340, 32'hFFFF_0000, 5'd3, 0, we, wv, rd, ill);
    check("rsi_3.we", {31'b0, we}, 32'd1);
    check("rsi_3.wval", wv, 32'h0000_000F);
    do_op("rci_6", 3'b111, 12'h340, 32'hFFFF_FFFF, 5'd6, 0, we, wv, rd, ill);
    check("rci_6.wval", wv, 32'h0000_0009);
    do_op("rs_zero", 3'b010, 12'h340, 32'h0000_0000, 5'd7, 0, we, wv, rd, ill);
    check("rs_zero.we", {31'b0, we}, 32'd1);
    check("rs_zero.wval", wv, 32'h0000_0009);
    do_op("rwi_0", 3'b101, 12'h340, 32'hFFFF_FFFF, 5'd0, 0, we, wv, rd, ill);
    check("rwi_0.we", {31'b0, we}, 32'd1);
    check("rwi_0.wval", wv, 32'h0);
    check("rwi_0.rd", rd, 32'h0000_0009);
    do_op("readback", 3'b010, 12'h340, 32'h0, 5'd0, 0, we, wv, rd, ill);
    check("readback.rd", rd, 32'h0);

    // 4: read-only CSR
    do_op("ro_w", 3'b001, 12'hC00, 32'h0000_0001, 5'd1, 0, we, wv, rd, ill);
    check("ro_w.ill", {31'b0, ill}, 32'd1);
    check("ro_w.rd", rd, 32'h0);
    check("ro_w.we", {31'b0, we}, 32'd0);
    do_op("ro_r", 3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, 0, we, wv, rd, ill);
    check("ro_r.ill", {31'b0, ill}, 32'd0);
    check("ro_r.rd", rd, 32'h0000_ABCD);
    check("ro_r.we", {31'b0, we}, 32'd0);

    // 5: reserved funct3 encodings, with back-pressure on the response
    poke(12'h340, 32'h0000_0077);
    do_op("f100", 3'b100, 12'h340, 32'h1111_1111, 5'd1, 5, we, wv, rd, ill);
    check("f100.ill", {31'b0, ill}, 32'd1);
    check("f100.we", {31'b0, we}, 32'd0);
    check("f100.rd", rd, 32'h0);
    do_op("f000", 3'b000, 12'h340, 32'h1111_1111, 5'd1, 0, we, wv, rd, ill);
    check("f000.ill", {31'b0, ill}, 32'd1);
    check("f000.we", {31'b0, we}, 32'd0);
    do_op("hold_ok", 3'b010, 12'h340, 32'h0, 5'd0, 3, we, wv, rd, ill);
    check("hold_ok.rd", rd, 32'h0000_0077);

    // 6: reset asserted during the WRITE cycle aborts the op
    poke(12'h340, 32'h0000_0055);
    req_valid    = 1'b1;
    req_funct3   = 3'b001;
    req_csr_addr = 12'h340;
    req_rs1_val  = 32'h0000_0099;
    req_rs1_idx  = 5'd1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort.we", {31'b0, w_enable}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("abort.ready", {31'b0, req_ready}, 32'd1);
    check("abort.no_resp", {31'b0, resp_valid}, 32'd0);
    do_op("abort_rb", 3'b010, 12'h340, 32'h0, 5'd0, 0, we, wv, rd, ill);
    check("abort_rb.rd", rd, 32'h0000_0055);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
